// File: rtl/debug_bridge.sv
// UART debug bridge: host commands for ping, pause/resume/step, breakpoints and program
// download, with signal snapshot frames sent back over the same serial link.
module debug_bridge #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ISA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned SIG_WORDS    = 2,
  parameter int unsigned BP_COUNT     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  output logic                          uart_tx,
  input  logic [ISA_WIDTH-1:0]          pc,
  input  logic [SIG_WORDS*ISA_WIDTH-1:0] signals,
  output logic [ADDR_WIDTH-1:0]         uart_addr,
  output logic [ISA_WIDTH-1:0]          uart_data,
  output logic                          uart_write_enable,
  output logic                          debug_pause,
  output logic                          uart_complete
);

  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned IsaBytes = ISA_WIDTH / 8;
  localparam int unsigned SigW     = SIG_WORDS * ISA_WIDTH;
  localparam int unsigned SigBytes = SigW / 8;
  localparam int unsigned Timeout  = 10 * CLKS_PER_BIT;
  localparam int unsigned IdleW    = $clog2(Timeout + 1);
  localparam int unsigned ByteCntW = $clog2(IsaBytes + 1);
  localparam int unsigned IdxW     = $clog2(SigBytes + 2);
  localparam int unsigned BpW      = (BP_COUNT > 1) ? $clog2(BP_COUNT) : 1;

  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [2:0] {CmdOpcode, CmdProgram, CmdBpIdx, CmdBpPc, CmdClrIdx} cmd_state_e;

  // ---------------- receiver ----------------
  logic            rx_s1_q, rx_s2_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid;
  logic [7:0]      rx_byte;

  assign rx_byte = rx_shift_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_state_d = RxStart;
      end
      RxStart: if (rx_cnt_q == HalfLast) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RxIdle : RxData;
      end
      RxData: if (rx_cnt_q == BitLast) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RxStop;
      end
      RxStop: if (rx_cnt_q == BitLast) begin
        rx_valid   = rx_s2_q;  // low stop bit drops the byte
        rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;
  logic            tx_go;
  logic [7:0]      tx_byte;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (tx_go) begin
          tx_shift_d = tx_byte;
          tx_d       = 1'b0;
          tx_state_d = TxStart;
        end
      end
      TxStart: if (tx_cnt_q == BitLast) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
        tx_state_d = TxData;
      end
      TxData: if (tx_cnt_q == BitLast) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_d       = 1'b1;
          tx_state_d = TxStop;
        end else begin
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
          tx_bit_d   = tx_bit_q + 1'b1;
        end
      end
      TxStop: if (tx_cnt_q == BitLast) tx_state_d = TxIdle;
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign uart_tx = tx_q;

  // ---------------- frame sequencer with one pending slot ----------------
  logic            req_new, req_sig;
  logic            frame_busy_q, frame_busy_d, frame_sig_q, frame_sig_d;
  logic [IdxW-1:0] frame_idx_q, frame_idx_d, frame_last;
  logic [SigW-1:0] snap_q, snap_d, pend_snap_q, pend_snap_d;
  logic            pend_valid_q, pend_valid_d, pend_sig_q, pend_sig_d;

  assign frame_last = frame_sig_q ? IdxW'(SigBytes + 1) : IdxW'(1);
  assign tx_byte    = (frame_idx_q == '0) ? (frame_sig_q ? 8'h01 : 8'h02) : snap_q[7:0];

  always_comb begin
    frame_busy_d = frame_busy_q;
    frame_sig_d  = frame_sig_q;
    frame_idx_d  = frame_idx_q;
    snap_d       = snap_q;
    pend_valid_d = pend_valid_q;
    pend_sig_d   = pend_sig_q;
    pend_snap_d  = pend_snap_q;
    tx_go        = 1'b0;
    if (frame_busy_q && tx_state_q == TxIdle) begin
      if (frame_idx_q != frame_last) begin
        tx_go       = 1'b1;
        frame_idx_d = frame_idx_q + 1'b1;
        if (frame_idx_q != '0) snap_d = snap_q >> 8;
      end else begin
        frame_busy_d = 1'b0;
      end
    end
    if (!frame_busy_q) begin
      if (pend_valid_q) begin
        frame_busy_d = 1'b1;
        frame_sig_d  = pend_sig_q;
        snap_d       = pend_snap_q;
        frame_idx_d  = '0;
        pend_valid_d = 1'b0;
      end else if (req_new) begin
        frame_busy_d = 1'b1;
        frame_sig_d  = req_sig;
        snap_d       = signals;
        frame_idx_d  = '0;
      end
    end
    // A request not started directly lands in the slot if the slot is (or is becoming) free.
    if (req_new && (frame_busy_q ? !pend_valid_q : pend_valid_q)) begin
      pend_valid_d = 1'b1;
      pend_sig_d   = req_sig;
      pend_snap_d  = signals;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_busy_q <= 1'b0;
      frame_sig_q  <= 1'b0;
      frame_idx_q  <= '0;
      snap_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_sig_q   <= 1'b0;
      pend_snap_q  <= '0;
    end else begin
      frame_busy_q <= frame_busy_d;
      frame_sig_q  <= frame_sig_d;
      frame_idx_q  <= frame_idx_d;
      snap_q       <= snap_d;
      pend_valid_q <= pend_valid_d;
      pend_sig_q   <= pend_sig_d;
      pend_snap_q  <= pend_snap_d;
    end
  end

  // ---------------- command decoder ----------------
  cmd_state_e          cmd_q, cmd_d;
  logic                pause_q, pause_d, step_q, step_d;
  logic [BP_COUNT-1:0] bp_en_q, bp_en_d;
  logic [ISA_WIDTH-1:0] bp_pc_q [BP_COUNT];
  logic [ISA_WIDTH-1:0] bp_pc_d [BP_COUNT];
  logic [BpW-1:0]      bp_idx_q, bp_idx_d;
  logic                bp_ok_q, bp_ok_d, bp_hit;
  logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [ISA_WIDTH-1:0] word_q, word_d, word_next, data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                we_q, we_d, complete_q, complete_d;
  logic [IdleW-1:0]    idle_q, idle_d;
  logic                last_byte;

  assign word_next = (word_q >> 8) | (ISA_WIDTH'(rx_byte) << (ISA_WIDTH - 8));
  assign last_byte = (byte_cnt_q == ByteCntW'(IsaBytes - 1));

  always_comb begin
    bp_hit = 1'b0;
    for (int unsigned i = 0; i < BP_COUNT; i++) begin
      if (bp_en_q[i] && pc == bp_pc_q[i]) bp_hit = 1'b1;
    end
  end

  always_comb begin
    cmd_d      = cmd_q;
    pause_d    = pause_q;
    step_d     = 1'b0;
    bp_en_d    = bp_en_q;
    bp_pc_d    = bp_pc_q;
    bp_idx_d   = bp_idx_q;
    bp_ok_d    = bp_ok_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    data_d     = data_q;
    addr_d     = we_q ? addr_q + 1'b1 : addr_q;
    we_d       = 1'b0;
    complete_d = 1'b0;
    idle_d     = idle_q;
    req_new    = 1'b0;
    req_sig    = 1'b0;

    if (step_q || (!pause_q && bp_hit)) begin
      pause_d = 1'b1;
      req_new = 1'b1;
      req_sig = 1'b1;
    end

    unique case (cmd_q)
      CmdOpcode: if (rx_valid) begin
        case (rx_byte)
          8'h03: begin req_new = 1'b1; req_sig = 1'b0; end
          8'h04: begin pause_d = 1'b1; req_new = 1'b1; req_sig = 1'b1; end
          8'h05: pause_d = 1'b0;
          8'h06: if (pause_q) begin pause_d = 1'b0; step_d = 1'b1; end
          8'h07: begin
            pause_d    = 1'b1;
            addr_d     = '0;
            byte_cnt_d = '0;
            idle_d     = '0;
            cmd_d      = CmdProgram;
          end
          8'h08: cmd_d = CmdBpIdx;
          8'h09: cmd_d = CmdClrIdx;
          default: ;
        endcase
      end
      CmdProgram: begin
        if (!rx_s2_q || rx_state_q != RxIdle) begin
          idle_d = '0;
        end else if (idle_q == IdleW'(Timeout - 1)) begin
          complete_d = 1'b1;
          byte_cnt_d = '0;
          cmd_d      = CmdOpcode;
        end else begin
          idle_d = idle_q + 1'b1;
        end
        if (rx_valid) begin
          word_d     = word_next;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (last_byte) begin
            byte_cnt_d = '0;
            data_d     = word_next;
            we_d       = 1'b1;
          end
        end
      end
      CmdBpIdx: if (rx_valid) begin
        bp_idx_d   = rx_byte[BpW-1:0];
        bp_ok_d    = 32'(rx_byte) < BP_COUNT;
        byte_cnt_d = '0;
        cmd_d      = CmdBpPc;
      end
      CmdBpPc: if (rx_valid) begin
        word_d     = word_next;
        byte_cnt_d = byte_cnt_q + 1'b1;
        if (last_byte) begin
          byte_cnt_d = '0;
          cmd_d      = CmdOpcode;
          if (bp_ok_q) begin
            bp_pc_d[bp_idx_q] = word_next;
            bp_en_d[bp_idx_q] = 1'b1;
          end
        end
      end
      CmdClrIdx: if (rx_valid) begin
        if (32'(rx_byte) < BP_COUNT) bp_en_d[rx_byte[BpW-1:0]] = 1'b0;
        cmd_d = CmdOpcode;
      end
      default: cmd_d = CmdOpcode;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= CmdOpcode;
      pause_q    <= 1'b1;
      step_q     <= 1'b0;
      bp_en_q    <= '0;
      bp_pc_q    <= '{default: '0};
      bp_idx_q   <= '0;
      bp_ok_q    <= 1'b0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      complete_q <= 1'b0;
      idle_q     <= '0;
    end else begin
      cmd_q      <= cmd_d;
      pause_q    <= pause_d;
      step_q     <= step_d;
      bp_en_q    <= bp_en_d;
      bp_pc_q    <= bp_pc_d;
      bp_idx_q   <= bp_idx_d;
      bp_ok_q    <= bp_ok_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      complete_q <= complete_d;
      idle_q     <= idle_d;
    end
  end

  assign uart_addr         = addr_q;
  assign uart_data         = data_q;
  assign uart_write_enable = we_q;
  assign debug_pause       = pause_q;
  assign uart_complete     = complete_q;

endmodule

// File: tb/tb_debug_bridge.sv
// Directed bench for debug_bridge: drives host bytes on uart_rx and decodes uart_tx.
module tb_debug_bridge;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [31:0] pc = 32'h0;
  logic [63:0] signals = 64'h0;
  logic [13:0] uart_addr;
  logic [31:0] uart_data;
  logic        uart_write_enable, debug_pause, uart_complete;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cmp_cnt = 0;
  int cmp_t = 0;
  int low_cnt = 0;

  logic [8:0]  txq[$];
  int          txq_t[$];
  logic [45:0] wrq[$];

  debug_bridge #(
    .CLKS_PER_BIT(CPB),
    .ISA_WIDTH   (32),
    .ADDR_WIDTH  (14),
    .SIG_WORDS   (2),
    .BP_COUNT    (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .uart_rx          (uart_rx),
    .uart_tx          (uart_tx),
    .pc               (pc),
    .signals          (signals),
    .uart_addr        (uart_addr),
    .uart_data        (uart_data),
    .uart_write_enable(uart_write_enable),
    .debug_pause      (debug_pause),
    .uart_complete    (uart_complete)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_write_enable === 1'b1) wrq.push_back({uart_addr, uart_data});
    if (uart_complete === 1'b1) begin
      cmp_cnt <= cmp_cnt + 1;
      cmp_t   <= cyc;
    end
  end

  always @(negedge clk) begin
    if (debug_pause === 1'b0) low_cnt <= low_cnt + 1;
  end

  // Serial decoder for uart_tx: records {stop_bit, data} and the start cycle.
  initial begin : tx_mon
    logic [7:0] b;
    logic       s;
    int         t0;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        s = uart_tx;
        txq.push_back({s, b});
        txq_t.push_back(t0);
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && txq.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    checks++; if (debug_pause !== 1'b1) begin errors++; $display("FAIL reset_pause: got %b expected 1", debug_pause); end
    checks++; if (uart_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", uart_write_enable); end
    checks++; if (uart_complete !== 1'b0) begin errors++; $display("FAIL reset_complete: got %b expected 0", uart_complete); end
    checks++; if (uart_addr !== 14'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", uart_addr); end
    checks++; if (uart_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", uart_data); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_ping();
    int base, tend;
    base = txq.size();
    send_byte(8'h03, 1'b1);
    tend = cyc;
    wait_tx(base + 1, 400);
    repeat (200) @(negedge clk);
    checks++; if (txq.size() != base + 1) begin errors++; $display("FAIL ping_count: got %0d bytes expected 1", txq.size() - base); end
    checks++; if (txq[base] !== 9'h102) begin errors++; $display("FAIL ping_byte: got %h expected 102", txq[base]); end
    checks++; if (txq_t[base] - tend > 2 * CPB) begin errors++; $display("FAIL ping_latency: got %0d cycles expected <= %0d", txq_t[base] - tend, 2 * CPB); end
  endtask

  task automatic test_program();
    int wb, cb, tend;
    logic [7:0] prog [8];
    prog = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wb = wrq.size();
    cb = cmp_cnt;
    send_byte(8'h07, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b1);
    tend = cyc;
    for (int i = 0; i < 400 && cmp_cnt == cb; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    checks++; if (wrq.size() != wb + 2) begin errors++; $display("FAIL prog_strobes: got %0d expected 2", wrq.size() - wb); end
    checks++; if (wrq[wb] !== {14'd0, 32'h12345678}) begin errors++; $display("FAIL prog_word0: got %h expected %h", wrq[wb], {14'd0, 32'h12345678}); end
    checks++; if (wrq[wb+1] !== {14'd1, 32'hDEADBEEF}) begin errors++; $display("FAIL prog_word1: got %h expected %h", wrq[wb+1], {14'd1, 32'hDEADBEEF}); end
    checks++; if (cmp_cnt - cb != 1) begin errors++; $display("FAIL prog_complete_count: got %0d expected 1", cmp_cnt - cb); end
    checks++; if (cmp_t - tend < 145 || cmp_t - tend > 170) begin errors++; $display("FAIL prog_complete_time: got %0d cycles expected 145..170", cmp_t - tend); end
    checks++; if (debug_pause !== 1'b1) begin errors++; $display("FAIL prog_pause: got %b expected 1", debug_pause); end
    checks++; if (uart_addr !== 14'd2) begin errors++; $display("FAIL prog_addr: got %0d expected 2", uart_addr); end
  endtask

  task automatic test_breakpoint();
    int base;
    logic [63:0] sig_exp;
    logic [7:0]  exp;
    send_byte(8'h05, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if (debug_pause !== 1'b0) begin errors++; $display("FAIL resume_pause: got %b expected 0", debug_pause); end
    send_byte(8'h08, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (5) @(negedge clk);
    sig_exp = 64'h8877665544332211;
    signals = sig_exp;
    base = txq.size();
    pc = 32'h10;
    @(negedge clk);
    checks++; if (debug_pause !== 1'b1) begin errors++; $display("FAIL bp_pause: got %b expected 1", debug_pause); end
    signals = 64'hFFFF_FFFF_FFFF_FFFF;
    pc = 32'h14;
    wait_tx(base + 9, 2500);
    checks++; if (txq.size() != base + 9) begin errors++; $display("FAIL bp_frame_len: got %0d expected 9", txq.size() - base); end
    for (int k = 0; k < 9; k++) begin
      exp = (k == 0) ? 8'h01 : sig_exp[8*(k-1) +: 8];
      checks++;
      if (txq[base+k] !== {1'b1, exp}) begin
        errors++; $display("FAIL bp_frame_byte%0d: got %h expected %h", k, txq[base+k], {1'b1, exp});
      end
    end
  endtask

  task automatic test_next();
    int base, l0;
    signals = 64'h0123456789ABCDEF;
    base = txq.size();
    l0 = low_cnt;
    send_byte(8'h06, 1'b1);
    wait_tx(base + 9, 2500);
    repeat (20) @(negedge clk);
    checks++; if (low_cnt - l0 != 1) begin errors++; $display("FAIL next_low_cycles: got %0d expected 1", low_cnt - l0); end
    checks++; if (debug_pause !== 1'b1) begin errors++; $display("FAIL next_pause: got %b expected 1", debug_pause); end
    checks++; if (txq.size() != base + 9) begin errors++; $display("FAIL next_frame_len: got %0d expected 9", txq.size() - base); end
    checks++; if (txq[base] !== 9'h101) begin errors++; $display("FAIL next_hdr: got %h expected 101", txq[base]); end
    checks++; if (txq[base+1] !== 9'h1EF) begin errors++; $display("FAIL next_sig0: got %h expected 1ef", txq[base+1]); end
    send_byte(8'h05, 1'b1);
    repeat (5) @(negedge clk);
    base = txq.size();
    send_byte(8'h06, 1'b1);
    repeat (300) @(negedge clk);
    checks++; if (debug_pause !== 1'b0) begin errors++; $display("FAIL next_running_pause: got %b expected 0", debug_pause); end
    checks++; if (txq.size() != base) begin errors++; $display("FAIL next_running_tx: got %0d bytes expected 0", txq.size() - base); end
  endtask

  task automatic test_back_to_back();
    int base;
    signals = 64'hCAFEF00D_12345678;
    base = txq.size();
    send_byte(8'h04, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h03, 1'b1);
    wait_tx(base + 10, 3000);
    repeat (400) @(negedge clk);
    checks++; if (txq.size() != base + 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", txq.size() - base); end
    checks++; if (txq[base] !== 9'h101) begin errors++; $display("FAIL b2b_hdr: got %h expected 101", txq[base]); end
    checks++; if (txq[base+1] !== 9'h178) begin errors++; $display("FAIL b2b_sig0: got %h expected 178", txq[base+1]); end
    checks++; if (txq[base+8] !== 9'h1CA) begin errors++; $display("FAIL b2b_sig7: got %h expected 1ca", txq[base+8]); end
    checks++; if (txq[base+9] !== 9'h102) begin errors++; $display("FAIL b2b_ping: got %h expected 102", txq[base+9]); end
    checks++;
    if (txq_t[base+9] - txq_t[base+8] > 10 * CPB + 10) begin
      errors++; $display("FAIL b2b_gap: got %0d cycles expected <= %0d", txq_t[base+9] - txq_t[base+8], 10 * CPB + 10);
    end
    checks++; if (debug_pause !== 1'b1) begin errors++; $display("FAIL b2b_pause: got %b expected 1", debug_pause); end
  endtask

  task automatic test_errors();
    int base;
    send_byte(8'h05, 1'b1);
    repeat (5) @(negedge clk);
    base = txq.size();
    send_byte(8'h03, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    send_byte(8'h08, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (200) @(negedge clk);
    checks++; if (txq.size() != base) begin errors++; $display("FAIL err_no_reply: got %0d bytes expected 0", txq.size() - base); end
    pc = 32'h03;
    repeat (5) @(negedge clk);
    checks++; if (debug_pause !== 1'b0) begin errors++; $display("FAIL err_bad_idx: got pause %b expected 0", debug_pause); end
    pc = 32'h14;
    send_byte(8'h09, 1'b1);
    send_byte(8'h02, 1'b1);
    pc = 32'h10;
    repeat (5) @(negedge clk);
    checks++; if (debug_pause !== 1'b0) begin errors++; $display("FAIL err_clr_bp: got pause %b expected 0", debug_pause); end
    pc = 32'h14;
    send_byte(8'h03, 1'b1);
    wait_tx(base + 1, 400);
    checks++; if (txq[base] !== 9'h102) begin errors++; $display("FAIL err_ping_after: got %h expected 102", txq[base]); end
  endtask

  task automatic test_reset_abort();
    int wb, cb;
    wb = wrq.size();
    cb = cmp_cnt;
    send_byte(8'h07, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (debug_pause !== 1'b1) begin errors++; $display("FAIL abort_pause: got %b expected 1", debug_pause); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b expected 1", uart_tx); end
    uart_rx = 1'b1;
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    checks++; if (wrq.size() != wb) begin errors++; $display("FAIL abort_write: got %0d strobes expected 0", wrq.size() - wb); end
    checks++; if (cmp_cnt != cb) begin errors++; $display("FAIL abort_complete: got %0d pulses expected 0", cmp_cnt - cb); end
    checks++; if (uart_addr !== 14'd0) begin errors++; $display("FAIL abort_addr: got %0d expected 0", uart_addr); end
  endtask

  initial begin
    test_reset();
    test_ping();
    test_program();
    test_breakpoint();
    test_next();
    test_back_to_back();
    test_errors();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_bridge.md
DEBUG_BRIDGE -- requirements
Module: debug_bridge

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200); legal values are 8 or greater.
REQ-002 SHALL have parameter ISA_WIDTH, default 32, meaning instruction/PC width; it SHALL be a multiple of 8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 14, meaning program word-address width.
REQ-004 SHALL have parameter SIG_WORDS, default 2, meaning the number of ISA_WIDTH words in the signal snapshot.
REQ-005 SHALL have parameter BP_COUNT, default 4, meaning the number of breakpoint slots (1..16).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port uart_rx, input, 1, serial in (8N1, idle high).
REQ-009 SHALL have port uart_tx, output, 1, serial out (8N1, idle high).
REQ-010 SHALL have port pc, input, ISA_WIDTH, the CPU fetch PC.
REQ-011 SHALL have port signals, input, SIG_WORDS*ISA_WIDTH, the snapshot sent to the host.
REQ-012 SHALL have port uart_addr, output, ADDR_WIDTH, program write word address.
REQ-013 SHALL have port uart_data, output, ISA_WIDTH, program write data.
REQ-014 SHALL have port uart_write_enable, output, 1, a one-cycle program-write strobe.
REQ-015 SHALL have port debug_pause, output, 1, CPU hold request.
REQ-016 SHALL have port uart_complete, output, 1, a one-cycle end-of-programming pulse.

Function
REQ-017 SHALL synchronise uart_rx through two flops, and no clock other than clk or its enables SHALL be used.
REQ-018 RX FSM IDLE->START->DATA->STOP SHALL detect the start bit on low, re-check at CLKS_PER_BIT/2 (high returns to IDLE), then sample 8 data bits LSB first at bit centres.
REQ-019 A low stop bit SHALL discard the byte (framing error); a valid byte SHALL raise a one-cycle rx_valid.
REQ-020 TX SHALL send start bit, 8 data bits LSB first, then stop bit, each for CLKS_PER_BIT cycles; uart_tx SHALL idle high.
REQ-021 Command FSM states SHALL be OPCODE, PROGRAM, BP_IDX, BP_PC, CLR_IDX.
REQ-022 Opcodes: 0x03 PING -> reply 0x02; 0x04 PAUSE -> debug_pause=1 plus signal frame; 0x05 RESUME -> debug_pause=0; 0x06 NEXT; 0x07 PROGRAM; 0x08 SET_BP (idx byte, then ISA_WIDTH/8 PC bytes LSB first); 0x09 CLR_BP (idx byte).
REQ-023 Unknown opcodes SHALL be ignored.
REQ-024 A breakpoint index >= BP_COUNT SHALL be ignored, and its payload bytes SHALL still be consumed.
REQ-025 Signal frame: byte 0x01, then SIG_WORDS*ISA_WIDTH/8 bytes of signals LSB first, latched on the cycle the frame is requested.
REQ-026 Breakpoint hit: when debug_pause=0 and pc equals any enabled slot, debug_pause SHALL be 1 on the next cycle and a signal frame SHALL be requested.
REQ-027 NEXT while paused SHALL drop debug_pause for exactly one cycle, reassert it, and send a signal frame.
REQ-028 NEXT while running SHALL be ignored.
REQ-029 TX arbitration: a request arriving while a frame is in progress SHALL be held in a single pending slot and sent after that frame; further requests while the slot is full SHALL be dropped.
REQ-030 PROGRAM SHALL set debug_pause=1 and clear the word address to 0.
REQ-031 In PROGRAM, every ISA_WIDTH/8 bytes (LSB first) SHALL form uart_data; uart_write_enable SHALL pulse one cycle with uart_addr stable, and uart_addr SHALL increment on the cycle after the pulse.
REQ-032 uart_addr SHALL wrap modulo 2^ADDR_WIDTH.
REQ-033 PROGRAM SHALL end when uart_rx stays idle for 10*CLKS_PER_BIT cycles after the last stop bit: uart_complete pulses for one cycle, any partial word is discarded, the state returns to OPCODE, and debug_pause stays 1.
REQ-034 The serial protocol SHALL NOT accept commands during PROGRAM; all bytes are data.

Reset
REQ-035 rst_n low SHALL immediately force: uart_tx=1, debug_pause=1, uart_write_enable=0, uart_complete=0, uart_addr=0, uart_data=0, all breakpoints disabled, the pending slot empty, and all FSMs idle/OPCODE.
REQ-036 Reset mid-frame (RX or TX) SHALL abort the frame, and no partial write SHALL occur after release.

Verification (CLKS_PER_BIT=16, ISA_WIDTH=32, SIG_WORDS=2, BP_COUNT=4)
REQ-037 Send PING 0x03 -> uart_tx carries one byte 0x02, starting within 2 bit times.
REQ-038 Send PROGRAM 0x07 then bytes 78 56 34 12 EF BE AD DE, then idle -> writes 0x12345678@0 and 0xDEADBEEF@1, one strobe each, then one uart_complete pulse after 160 idle cycles.
REQ-039 Send RESUME, then SET_BP 0x02, 10 00 00 00; drive pc to 0x10 -> debug_pause=1 the next cycle; frame 01 followed by 8 signals bytes.
REQ-040 While paused send NEXT -> debug_pause low for exactly 1 cycle, then a frame; NEXT while running -> no change.
REQ-041 Send PING while a signal frame is transmitting -> 0x02 follows the frame immediately; a second PING in that window is dropped.
REQ-042 Send a byte with a low stop bit, plus SET_BP with index 7 -> no action, and later commands decode correctly.
